// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, captures the same-cycle cache word and queues {pc, inst} for decode.
// Optional same-cycle queue bypass when empty is enabled with `define FETCH_BYPASS_EN.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic [ADDR_WIDTH-1:0]   pc_out,
  input  logic [DATA_WIDTH-1:0]   inst_in,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [ADDR_WIDTH-1:0]   deq_pc,
  output logic [DATA_WIDTH-1:0]   deq_inst,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FULL} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [ADDR_WIDTH-1:0]   pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0]   inst_mem [DEPTH];

  logic fetch_en_c, bypass_c, pop_c, qpop_c, push_c, wr_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_BOOT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN:  if (wr_c && !qpop_c && (count_q == DEPTH_C - CNT_W'(1))) state_d = S_FULL;
      S_FULL: if (pop_c || redirect_valid) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  // FSM outputs
  always_comb begin
    fetch_en_c = (state_q != S_BOOT);
  end

`ifdef FETCH_BYPASS_EN
  assign bypass_c  = (state_q == S_RUN) && (count_q == '0) && !redirect_valid;
  assign deq_pc    = bypass_c ? pc_q    : pc_mem[head_q];
  assign deq_inst  = bypass_c ? inst_in : inst_mem[head_q];
`else
  assign bypass_c  = 1'b0;
  assign deq_pc    = pc_mem[head_q];
  assign deq_inst  = inst_mem[head_q];
`endif

  assign deq_valid = (count_q != '0) || bypass_c;
  assign pop_c     = deq_valid && deq_ready;
  assign qpop_c    = pop_c && !bypass_c;
  assign push_c    = fetch_en_c && !redirect_valid && ((count_q < DEPTH_C) || pop_c);
  // A bypassed pair that decode takes this cycle never lands in storage.
  assign wr_c      = push_c && !(bypass_c && deq_ready);

  // Pointer, occupancy and PC next-state
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_c) pc_d   = pc_q + ADDR_WIDTH'(4);
      if (wr_c)   tail_d = tail_q + PTR_W'(1);
      if (qpop_c) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_c) - CNT_W'(qpop_c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset
  always_ff @(posedge clk) begin
    if (wr_c) begin
      pc_mem[tail_q]   <= pc_q;
      inst_mem[tail_q] <= inst_in;
    end
  end

  assign pc_out = pc_q;
  assign count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level model checked every negedge plus directed literal checks.
module tb_fetch_unit;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          redirect_valid = 1'b0;
  logic          deq_ready = 1'b1;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] pc_out, deq_pc;
  logic [DW-1:0] inst_in, deq_inst;
  logic          deq_valid;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] cache_word(input logic [AW-1:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  always_comb inst_in = cache_word(pc_out);

  fetch_unit dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_out(pc_out), .inst_in(inst_in), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_inst(deq_inst), .count(count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a started flag, a PC and a queue of {pc, inst} pairs
  logic [AW-1:0]    m_pc = '0;
  bit               m_run = 1'b0;
  logic [AW+DW-1:0] m_q[$];
  logic [AW+DW-1:0] m_head;
  bit               m_b, m_pop, m_room, m_v;

  function automatic bit m_byp();
`ifdef FETCH_BYPASS_EN
    return m_run && (m_q.size() == 0) && !redirect_valid;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_pc  = '0;
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
      if (redirect_valid) m_pc = {redirect_pc[AW-1:2], 2'b00};
    end else begin
      m_b    = m_byp();
      m_pop  = ((m_q.size() != 0) || m_b) && deq_ready;
      m_room = (m_q.size() < D);
      if (redirect_valid) begin
        m_q.delete();
        m_pc = {redirect_pc[AW-1:2], 2'b00};
      end else begin
        if (m_pop && !m_b) void'(m_q.pop_front());
        if (m_room || m_pop) begin
          if (!(m_b && m_pop)) m_q.push_back({m_pc, cache_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_count", 64'(count), 64'(m_q.size()));
    chk("m_pc_out", 64'(pc_out), 64'(m_pc));
    m_v = (m_q.size() != 0) || m_byp();
    chk("m_deq_valid", 64'(deq_valid), 64'(m_v));
    if (m_v) begin
      m_head = (m_q.size() != 0) ? m_q[0] : {m_pc, cache_word(m_pc)};
      chk("m_deq_pc", 64'(deq_pc), 64'(m_head[AW+DW-1:DW]));
      chk("m_deq_inst", 64'(deq_inst), 64'(m_head[DW-1:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_pc_out", 64'(pc_out), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_valid", 64'(deq_valid), 64'h0);
    @(posedge clk); #1 reset = 1'b0;

    // Reset release
    tick();
`ifdef FETCH_BYPASS_EN
    chk("e1_byp_valid", 64'(deq_valid), 64'h1);
    chk("e1_byp_pc", 64'(deq_pc), 64'h0);
    tick();
    chk("e2_byp_pc", 64'(deq_pc), 64'h4);
    tick(); tick();
`else
    chk("e1_valid", 64'(deq_valid), 64'h0);
    tick();
    chk("e2_valid", 64'(deq_valid), 64'h1);
    chk("e2_pc", 64'(deq_pc), 64'h0);
    chk("e2_inst", 64'(deq_inst), 64'hDEADBEEF);
    tick();
    chk("e3_pc", 64'(deq_pc), 64'h4);
    chk("e3_inst", 64'(deq_inst), 64'hDEADBEEB);
    tick();
    chk("e4_pc", 64'(deq_pc), 64'h8);
    chk("e4_inst", 64'(deq_inst), 64'hDEADBEE7);
    chk("e4_pc_out", 64'(pc_out), 64'hC);
`endif

    // Fill and hold, then one pop+push while full
    deq_ready = 1'b0;
    repeat (6) tick();
    chk("fill_count", 64'(count), 64'h4);
`ifndef FETCH_BYPASS_EN
    chk("fill_pc_out", 64'(pc_out), 64'h18);
    chk("fill_deq_pc", 64'(deq_pc), 64'h8);
`endif
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    chk("full_pp_count", 64'(count), 64'h4);
`ifndef FETCH_BYPASS_EN
    chk("full_pp_deq_pc", 64'(deq_pc), 64'hC);
    chk("full_pp_pc_out", 64'(pc_out), 64'h1C);
`endif

    // Build count=3 after a redirect, then redirect-flush with a concurrent pop
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("rd40_count", 64'(count), 64'h0);
    chk("rd40_pc_out", 64'(pc_out), 64'h40);
    repeat (3) tick();
    chk("c3_count", 64'(count), 64'h3);
    chk("c3_deq_pc", 64'(deq_pc), 64'h40);
    chk("c3_pc_out", 64'(pc_out), 64'h4C);
    redirect_valid = 1'b1; redirect_pc = 32'h103; deq_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; deq_ready = 1'b0;
    chk("flush_count", 64'(count), 64'h0);
    chk("flush_pc_out", 64'(pc_out), 64'h100);
`ifndef FETCH_BYPASS_EN
    chk("flush_valid", 64'(deq_valid), 64'h0);
`endif
    tick();
    chk("flush_n1_valid", 64'(deq_valid), 64'h1);
    chk("flush_n1_deq_pc", 64'(deq_pc), 64'h100);
    chk("flush_n1_count", 64'(count), 64'h1);

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; deq_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_pc_out", 64'(pc_out), 64'hFFFF_FFFC);
`ifdef FETCH_BYPASS_EN
    chk("wrap_byp_pc0", 64'(deq_pc), 64'hFFFF_FFFC);
    tick();
    chk("wrap_byp_pc1", 64'(deq_pc), 64'h0);
    tick();
`else
    tick();
    chk("wrap_deq_pc0", 64'(deq_pc), 64'hFFFF_FFFC);
    chk("wrap_pc_out1", 64'(pc_out), 64'h0);
    tick();
    chk("wrap_deq_pc1", 64'(deq_pc), 64'h0);
    chk("wrap_pc_out2", 64'(pc_out), 64'h4);
`endif

    // Asynchronous reset mid-cycle
    deq_ready = 1'b0;
    tick();
`ifndef FETCH_BYPASS_EN
    chk("pre_rst_count", 64'(count), 64'h2);
`endif
    #3 reset = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'h0);
    chk("arst_valid", 64'(deq_valid), 64'h0);
    chk("arst_pc_out", 64'(pc_out), 64'h0);
    tick();
    reset = 1'b0;
    tick();
`ifndef FETCH_BYPASS_EN
    chk("arst_e1_valid", 64'(deq_valid), 64'h0);
`endif
    tick();
    chk("arst_e2_valid", 64'(deq_valid), 64'h1);
    chk("arst_e2_deq_pc", 64'(deq_pc), 64'h0);

    // Empty-queue latency (bypass vs. registered path)
    redirect_valid = 1'b1; redirect_pc = 32'h20; deq_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("lat_count", 64'(count), 64'h0);
    chk("lat_pc_out", 64'(pc_out), 64'h20);
`ifdef FETCH_BYPASS_EN
    chk("lat_byp_valid", 64'(deq_valid), 64'h1);
    chk("lat_byp_deq_pc", 64'(deq_pc), 64'h20);
    tick();
    chk("lat_byp_next_pc", 64'(deq_pc), 64'h24);
    chk("lat_byp_count", 64'(count), 64'h0);
`else
    chk("lat_valid", 64'(deq_valid), 64'h0);
    tick();
    chk("lat_n1_valid", 64'(deq_valid), 64'h1);
    chk("lat_n1_deq_pc", 64'(deq_pc), 64'h20);
`endif
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
